// File: rtl/pixel_write_buffer.sv
// Pixel write buffer: queues in-bounds pixel writes into a small FIFO and streams
// them to a framebuffer port, with a full-screen clear sweep that preempts draining.
module pixel_write_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SCR_W = 160,
    parameter int unsigned SCR_H = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    input  logic [7:0]  pix_x,
    input  logic [7:0]  pix_y,
    input  logic [23:0] pix_rgb,
    input  logic        clear_req,
    input  logic [8:0]  clear_color,
    input  logic        fb_ready,
    output logic        fb_we,
    output logic [14:0] fb_addr,
    output logic [8:0]  fb_data,
    output logic        fifo_full,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned ADDR_W    = 15;
    localparam int unsigned LAST_ADDR = SCR_W * SCR_H - 1;

    typedef struct packed {
        logic [14:0] addr;
        logic [8:0]  data;
    } fb_word_t;

    typedef enum logic {S_STREAM, S_CLEAR} state_t;

    state_t            state, state_nxt;
    fb_word_t          mem [DEPTH];
    fb_word_t          push_word, head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [14:0]       clear_addr;
    logic [8:0]        clear_col;
    logic              in_bounds, push, pop, clear_start, clear_done;
    logic              rgb_unused;

    // Address and colour are reduced once, at enqueue time.
    always_comb begin
        in_bounds      = (32'(pix_x) < SCR_W) && (32'(pix_y) < SCR_H);
        push_word.addr = ADDR_W'(pix_y) * ADDR_W'(SCR_W) + ADDR_W'(pix_x);
        push_word.data = {pix_rgb[23:21], pix_rgb[15:13], pix_rgb[7:5]};
        head           = mem[rd_ptr];
    end

    assign rgb_unused = ^{pix_rgb[20:16], pix_rgb[12:8], pix_rgb[4:0]};

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push      = pix_valid && in_bounds && ((count < CNT_W'(DEPTH)) || pop);
    assign fifo_full = (count == CNT_W'(DEPTH));
    assign busy      = (state == S_CLEAR) || (count != '0);

    always_ff @(posedge clk) begin
        if (reset) state <= S_STREAM;
        else       state <= state_nxt;
    end

    // Next state and framebuffer port; outputs idle at zero when nothing is presented.
    always_comb begin
        state_nxt   = state;
        fb_we       = 1'b0;
        fb_addr     = '0;
        fb_data     = '0;
        pop         = 1'b0;
        clear_start = 1'b0;
        clear_done  = 1'b0;
        case (state)
            S_STREAM: begin
                if (count != '0) begin
                    fb_we   = 1'b1;
                    fb_addr = head.addr;
                    fb_data = head.data;
                    pop     = fb_ready;
                end
                if (clear_req && (count == '0)) begin
                    state_nxt   = S_CLEAR;
                    clear_start = 1'b1;
                end
            end
            S_CLEAR: begin
                fb_we   = 1'b1;
                fb_addr = clear_addr;
                fb_data = clear_col;
                if (fb_ready && (clear_addr == ADDR_W'(LAST_ADDR))) begin
                    state_nxt  = S_STREAM;
                    clear_done = 1'b1;
                end
            end
            default: state_nxt = S_STREAM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            clear_addr <= '0;
            clear_col  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (pix_valid && in_bounds && !push) overflow <= 1'b1;
            if (clear_start) begin
                clear_col  <= clear_color;
                clear_addr <= '0;
            end else if ((state == S_CLEAR) && fb_ready) begin
                clear_addr <= clear_done ? '0 : clear_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed bench for pixel_write_buffer: vector table for streaming/bounds,
// hand sequences for backpressure, full push+pop, clear sweep and reset abort.
module tb_pixel_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_valid;
    logic [7:0]  pix_x, pix_y;
    logic [23:0] pix_rgb;
    logic        clear_req;
    logic [8:0]  clear_color;
    logic        fb_ready;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [8:0]  fb_data;
    logic        fifo_full, busy, overflow;

    int n_cmp = 0;
    int n_err = 0;

    pixel_write_buffer dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .clear_req(clear_req), .clear_color(clear_color),
        .fb_ready(fb_ready), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .fifo_full(fifo_full), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [23:0] rgb;
        logic        e_we;
        logic [14:0] e_addr;
        logic [8:0]  e_data;
        logic        e_busy;
    } vec_t;

    vec_t vt [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic drive_px(input logic v, input int x, input int y, input logic [23:0] rgb);
        pix_valid = v;
        pix_x     = 8'(x);
        pix_y     = 8'(y);
        pix_rgb   = rgb;
    endtask

    initial begin
        int bad;
        logic [8:0] e_dat [9];

        reset = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_rgb = '0;
        clear_req = 1'b0; clear_color = '0; fb_ready = 1'b1;

        // {valid, x, y, rgb, exp we, exp addr, exp data, exp busy}
        vt[0] = '{1'b1, 8'd3,   8'd2,   24'hFF8040, 1'b1, 15'd323,   9'h1E2, 1'b1};
        vt[1] = '{1'b0, 8'd0,   8'd0,   24'h000000, 1'b0, 15'd0,     9'h000, 1'b0};
        vt[2] = '{1'b1, 8'd160, 8'd0,   24'hFFFFFF, 1'b0, 15'd0,     9'h000, 1'b0};
        vt[3] = '{1'b1, 8'd0,   8'd120, 24'hFFFFFF, 1'b0, 15'd0,     9'h000, 1'b0};
        vt[4] = '{1'b1, 8'd159, 8'd119, 24'h000000, 1'b1, 15'd19199, 9'h000, 1'b1};
        vt[5] = '{1'b0, 8'd0,   8'd0,   24'h000000, 1'b0, 15'd0,     9'h000, 1'b0};
        vt[6] = '{1'b1, 8'd0,   8'd0,   24'hE0E0E0, 1'b1, 15'd0,     9'h1FF, 1'b1};
        vt[7] = '{1'b1, 8'd1,   8'd0,   24'h204060, 1'b1, 15'd1,     9'h053, 1'b1};
        vt[8] = '{1'b0, 8'd0,   8'd0,   24'h000000, 1'b0, 15'd0,     9'h000, 1'b0};

        step();
        reset = 1'b0;
        check("rst_we",   32'(fb_we),     32'd0);
        check("rst_addr", 32'(fb_addr),   32'd0);
        check("rst_data", 32'(fb_data),   32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_busy", 32'(busy),      32'd0);
        check("rst_ovf",  32'(overflow),  32'd0);

        for (int i = 0; i < 9; i++) begin
            drive_px(vt[i].v, int'(vt[i].x), int'(vt[i].y), vt[i].rgb);
            step();
            check($sformatf("vec%0d_we", i),   32'(fb_we),   32'(vt[i].e_we));
            check($sformatf("vec%0d_addr", i), 32'(fb_addr), 32'(vt[i].e_addr));
            check($sformatf("vec%0d_data", i), 32'(fb_data), 32'(vt[i].e_data));
            check($sformatf("vec%0d_busy", i), 32'(busy),    32'(vt[i].e_busy));
        end
        drive_px(1'b0, 0, 0, 24'h0);
        check("bounds_ovf", 32'(overflow), 32'd0);

        // Backpressure: nine pushes into a stalled FIFO, ninth is dropped.
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            e_dat[i] = {3'(i), 3'(7 - i), 3'(i)};
            drive_px(1'b1, i, 1, {3'(i), 5'b0, 3'(7 - i), 5'b0, 3'(i), 5'b0});
            step();
            check($sformatf("bp_hold_addr%0d", i), 32'(fb_addr), 32'd160);
            check($sformatf("bp_hold_data%0d", i), 32'(fb_data), 32'(e_dat[0]));
            if (i == 6) check("bp_full7", 32'(fifo_full), 32'd0);
            if (i == 7) begin
                check("bp_full8", 32'(fifo_full), 32'd1);
                check("bp_ovf8",  32'(overflow),  32'd0);
            end
            if (i == 8) check("bp_ovf9", 32'(overflow), 32'd1);
        end
        drive_px(1'b0, 0, 0, 24'h0);
        step();
        check("bp_stall_we",   32'(fb_we),   32'd1);
        check("bp_stall_addr", 32'(fb_addr), 32'd160);
        fb_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("bp_we%0d", k),   32'(fb_we),   32'd1);
            check($sformatf("bp_addr%0d", k), 32'(fb_addr), 32'(160 + k));
            check($sformatf("bp_data%0d", k), 32'(fb_data), 32'(e_dat[k]));
            step();
        end
        check("bp_done_we",   32'(fb_we),    32'd0);
        check("bp_done_busy", 32'(busy),     32'd0);
        check("bp_ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO with a simultaneous pop accepts the push.
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_px(1'b1, 10 + i, 0, 24'h0);
            step();
        end
        check("fp_full_before", 32'(fifo_full), 32'd1);
        fb_ready = 1'b1;
        drive_px(1'b1, 50, 0, 24'h0);
        step();
        drive_px(1'b0, 0, 0, 24'h0);
        check("fp_full_after", 32'(fifo_full), 32'd1);
        check("fp_ovf",        32'(overflow),  32'd0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("fp_addr%0d", k), 32'(fb_addr), (k < 7) ? 32'(11 + k) : 32'd50);
            step();
        end
        check("fp_empty_we", 32'(fb_we), 32'd0);

        // Clear sweep with a pixel pushed mid-clear and an ignored second request.
        do_reset();
        fb_ready = 1'b1;
        clear_req = 1'b1; clear_color = 9'h1C0;
        step();
        clear_req = 1'b0; clear_color = 9'h000;
        check("clr_start_busy", 32'(busy), 32'd1);
        bad = 0;
        for (int k = 0; k < 19200; k++) begin
            if (fb_we !== 1'b1 || fb_addr !== 15'(k) || fb_data !== 9'h1C0) bad++;
            if (k == 100) drive_px(1'b1, 5, 5, 24'hFFFFFF);
            if (k == 200) begin clear_req = 1'b1; clear_color = 9'h03F; end
            step();
            drive_px(1'b0, 0, 0, 24'h0);
            clear_req = 1'b0;
        end
        check("clr_sweep_bad", 32'(bad), 32'd0);
        check("clr_drain_we",   32'(fb_we),   32'd1);
        check("clr_drain_addr", 32'(fb_addr), 32'd805);
        check("clr_drain_data", 32'(fb_data), 32'h1FF);
        clear_req = 1'b1; clear_color = 9'h0F0;
        step();
        clear_req = 1'b0;
        check("clr_ign_we",   32'(fb_we), 32'd0);
        check("clr_ign_busy", 32'(busy),  32'd0);
        step();
        check("clr_ign_we2", 32'(fb_we), 32'd0);

        // Reset mid-clear loses queued pixels and beats simultaneous requests.
        clear_req = 1'b1; clear_color = 9'h0AA;
        step();
        clear_req = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (k == 10) drive_px(1'b1, 2, 2, 24'hFFFFFF);
            step();
            drive_px(1'b0, 0, 0, 24'h0);
        end
        check("rc_addr500", 32'(fb_addr), 32'd500);
        reset = 1'b1; clear_req = 1'b1;
        drive_px(1'b1, 1, 1, 24'hFFFFFF);
        step();
        reset = 1'b0; clear_req = 1'b0;
        drive_px(1'b0, 0, 0, 24'h0);
        check("rc_we",   32'(fb_we),   32'd0);
        check("rc_busy", 32'(busy),    32'd0);
        check("rc_addr", 32'(fb_addr), 32'd0);
        check("rc_data", 32'(fb_data), 32'd0);
        step();
        check("rc_idle_we", 32'(fb_we), 32'd0);
        clear_req = 1'b1; clear_color = 9'h155;
        step();
        clear_req = 1'b0;
        check("rc_new_addr", 32'(fb_addr), 32'd0);
        check("rc_new_data", 32'(fb_data), 32'h155);
        step();
        check("rc_new_addr1", 32'(fb_addr), 32'd1);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
